// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv
// Shared types and LFSR/MISR step functions for the dffq bank self-test.
// Widths 4..32 are handled by masking 32-bit values to the active width.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [31:0] width_mask(input int unsigned w);
        if (w >= 32) return '1;
        return (32'h1 << w) - 32'h1;
    endfunction

    // Feedback tap masks; bit n-1 set means tap n.
    function automatic logic [31:0] taps(input int unsigned w);
        logic [31:0] t;
        case (w)
            4:  t = 32'h0000_000C;
            5:  t = 32'h0000_0014;
            6:  t = 32'h0000_0030;
            7:  t = 32'h0000_0060;
            8:  t = 32'h0000_00B8;
            9:  t = 32'h0000_0110;
            10: t = 32'h0000_0240;
            11: t = 32'h0000_0500;
            12: t = 32'h0000_0829;
            13: t = 32'h0000_100D;
            14: t = 32'h0000_2015;
            15: t = 32'h0000_6000;
            16: t = 32'h0000_D008;
            17: t = 32'h0001_2000;
            18: t = 32'h0002_0400;
            19: t = 32'h0004_0023;
            20: t = 32'h0009_0000;
            21: t = 32'h0014_0000;
            22: t = 32'h0030_0000;
            23: t = 32'h0042_0000;
            24: t = 32'h00E1_0000;
            25: t = 32'h0120_0000;
            26: t = 32'h0200_0023;
            27: t = 32'h0400_0013;
            28: t = 32'h0900_0000;
            29: t = 32'h1400_0000;
            30: t = 32'h2000_0029;
            31: t = 32'h4800_0000;
            32: t = 32'h8020_0003;
            default: t = 32'h0;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v,
                                              input int unsigned w);
        logic [31:0] m;
        logic        fb;
        m  = width_mask(w);
        fb = ^(v & taps(w) & m);
        return ((v << 1) | {31'b0, fb}) & m;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] v,
                                              input logic [31:0] q,
                                              input int unsigned w);
        return lfsr_step(v, w) ^ (q & width_mask(w));
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_misr.sv
// WIDTH-bit multiple-input signature register with enable and sync clear.
// Exposes its next value so the caller can judge the final signature early.
module gf180mcu_fd_sc_mcu9t5v0__bist_misr
    import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_d_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = WIDTH'(misr_step(32'(sig_q), 32'(data_i), WIDTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o   = sig_q;
    assign sig_d_o = sig_d;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffq_bist.sv
// LFSR-driven self-test wrapper around a bank of dffq cells.
// Define GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN to add the ERR_CNT output.
module gf180mcu_fd_sc_mcu9t5v0__dffq_bist
    import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
    parameter int unsigned     WIDTH  = 8,
    parameter int unsigned     CYCLES = 256,
    parameter logic [WIDTH-1:0] GOLDEN = '0,
    parameter int unsigned     CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] SEED,
    output logic [WIDTH-1:0] D_OUT,
    input  logic [WIDTH-1:0] Q_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [WIDTH-1:0] SIGNATURE
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] ERR_CNT
`endif
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             en_q, en_d;
    logic             pass_q, pass_d;
    logic             start_ld;
    logic             last;
    logic             misr_en;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] sig_d;

    assign seed_eff = (SEED == '0) ? '1 : SEED;
    assign last     = (count_q == CW'(CYCLES - 1));
    assign misr_en  = en_q && !ABORT;

    always_comb begin
        state_d  = state_q;
        start_ld = 1'b0;
        unique case (state_q)
            S_IDLE:  start_ld = START;
            S_RUN:   if (last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  start_ld = START;
            default: state_d = S_IDLE;
        endcase
        if (start_ld) state_d = S_RUN;
        if (ABORT) begin
            state_d  = S_IDLE;
            start_ld = 1'b0;
        end
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        count_d = count_q;
        en_d    = (state_q == S_RUN) && !ABORT;
        pass_d  = pass_q;
        if (start_ld) begin
            lfsr_d  = seed_eff;
            count_d = '0;
        end else if (state_q == S_RUN && !last && !ABORT) begin
            lfsr_d  = WIDTH'(lfsr_step(32'(lfsr_q), WIDTH));
            count_d = count_q + 1'b1;
        end
        // Judge the signature the MISR is about to hold on DONE entry.
        if (state_q == S_DRAIN) pass_d = (sig_d == GOLDEN);
        if (start_ld || ABORT) pass_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            en_q    <= en_d;
            pass_q  <= pass_d;
        end
    end

    gf180mcu_fd_sc_mcu9t5v0__bist_misr #(
        .WIDTH(WIDTH)
    ) u_misr (
        .clk_i  (CLK),
        .rst_ni (RN),
        .clr_i  (start_ld),
        .en_i   (misr_en),
        .data_i (Q_IN),
        .sig_o  (SIGNATURE),
        .sig_d_o(sig_d)
    );

    assign BUSY  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign DONE  = (state_q == S_DONE);
    assign PASS  = pass_q;
    assign D_OUT = BUSY ? lfsr_q : '0;

`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN
    logic [WIDTH-1:0] dly_q;
    logic [CNT_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start_ld) begin
            err_d = '0;
        end else if (misr_en && Q_IN != dly_q && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            dly_q <= '0;
            err_q <= '0;
        end else begin
            dly_q <= D_OUT;
            err_q <= err_d;
        end
    end

    assign ERR_CNT = err_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffq_bist.sv
// Directed self-checking bench for the dffq bank self-test wrapper.
// A modelled dffq bank with an injectable stuck-at mask closes the loop.
module tb_gf180mcu_fd_sc_mcu9t5v0__dffq_bist;

    logic       CLK = 1'b0;
    logic       RN;
    logic       START;
    logic       ABORT;
    logic [7:0] SEED;
    logic [7:0] D_OUT;
    logic [7:0] Q_IN;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [7:0] SIGNATURE;
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN
    logic [7:0] ERR_CNT;
`endif

    logic [7:0] q_bank = 8'h00;
    logic [7:0] fmask  = 8'hFF;
    int         total  = 0;
    int         fails  = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) q_bank <= D_OUT;
    assign Q_IN = q_bank & fmask;

    gf180mcu_fd_sc_mcu9t5v0__dffq_bist #(
        .WIDTH (8),
        .CYCLES(4),
        .GOLDEN(8'h00),
        .CNT_W (8)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .START    (START),
        .ABORT    (ABORT),
        .SEED     (SEED),
        .D_OUT    (D_OUT),
        .Q_IN     (Q_IN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .SIGNATURE(SIGNATURE)
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN
        ,
        .ERR_CNT  (ERR_CNT)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] pat [4];

    initial begin
        pat[0] = 8'h01;
        pat[1] = 8'h02;
        pat[2] = 8'h04;
        pat[3] = 8'h08;
        RN    = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        SEED  = 8'h01;
        #3;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_pass", 32'(PASS), 32'd0);
        chk("rst_dout", 32'(D_OUT), 32'h00);
        chk("rst_sig", 32'(SIGNATURE), 32'h00);
        RN = 1'b1;
        tick();

        // golden run
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("gold_busy", 32'(BUSY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("gold_pat%0d", i), 32'(D_OUT), 32'(pat[i]));
            tick();
        end
        chk("gold_drain_busy", 32'(BUSY), 32'd1);
        chk("gold_drain_dout", 32'(D_OUT), 32'h08);
        chk("gold_drain_done", 32'(DONE), 32'd0);
        tick();
        chk("gold_done", 32'(DONE), 32'd1);
        chk("gold_busy_lo", 32'(BUSY), 32'd0);
        chk("gold_dout_idle", 32'(D_OUT), 32'h00);
        chk("gold_sig", 32'(SIGNATURE), 32'h00);
        chk("gold_pass", 32'(PASS), 32'd1);
        tick();
        chk("gold_done_hold", 32'(DONE), 32'd1);
        chk("gold_pass_hold", 32'(PASS), 32'd1);

        // stuck-at-0 on Q[0], restart straight from DONE
        fmask = 8'hFE;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("sa0_restart", 32'(BUSY), 32'd1);
        repeat (5) tick();
        chk("sa0_done", 32'(DONE), 32'd1);
        chk("sa0_sig", 32'(SIGNATURE), 32'h08);
        chk("sa0_pass", 32'(PASS), 32'd0);
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN
        chk("sa0_errcnt", 32'(ERR_CNT), 32'd1);
`endif
        fmask = 8'hFF;

        // ABORT and START together in DONE
        ABORT = 1'b1;
        START = 1'b1;
        tick();
        ABORT = 1'b0;
        START = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_pass", 32'(PASS), 32'd0);
        chk("abort_sig", 32'(SIGNATURE), 32'h08);
        tick();
        chk("abort_idle", 32'(BUSY), 32'd0);

        // zero seed falls back to all-ones
        SEED  = 8'h00;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("seed0_p0", 32'(D_OUT), 32'hFF);
        tick();
        chk("seed0_p1", 32'(D_OUT), 32'hFE);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("seed0_abort_dout", 32'(D_OUT), 32'h00);
        chk("seed0_abort_busy", 32'(BUSY), 32'd0);

        // asynchronous reset mid-run, on the third pattern
        SEED  = 8'h01;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        chk("rn_pat3", 32'(D_OUT), 32'h04);
        chk("rn_sig_pre", 32'(SIGNATURE), 32'h01);
        #2 RN = 1'b0;
        #1;
        chk("rn_busy", 32'(BUSY), 32'd0);
        chk("rn_dout", 32'(D_OUT), 32'h00);
        chk("rn_sig", 32'(SIGNATURE), 32'h00);
        #1 RN = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("rn_rerun_p0", 32'(D_OUT), 32'h01);
        repeat (5) tick();
        chk("rn_rerun_done", 32'(DONE), 32'd1);
        chk("rn_rerun_sig", 32'(SIGNATURE), 32'h00);
        chk("rn_rerun_pass", 32'(PASS), 32'd1);

        // START held through a faulty run, then a clean back-to-back run
        fmask = 8'hFE;
        START = 1'b1;
        tick();
        repeat (3) tick();
        chk("hold_no_restart", 32'(D_OUT), 32'h08);
        tick();
        chk("hold_drain", 32'(D_OUT), 32'h08);
        tick();
        chk("hold_done", 32'(DONE), 32'd1);
        chk("hold_sig", 32'(SIGNATURE), 32'h08);
        chk("hold_pass", 32'(PASS), 32'd0);
        fmask = 8'hFF;
        tick();
        chk("hold_restart_busy", 32'(BUSY), 32'd1);
        chk("hold_restart_done", 32'(DONE), 32'd0);
        chk("hold_restart_dout", 32'(D_OUT), 32'h01);
        chk("hold_fresh_sig", 32'(SIGNATURE), 32'h00);
        repeat (5) tick();
        START = 1'b0;
        chk("hold2_done", 32'(DONE), 32'd1);
        chk("hold2_sig", 32'(SIGNATURE), 32'h00);
        chk("hold2_pass", 32'(PASS), 32'd1);
`ifdef GF180MCU_FD_SC_MCU9T5V0_BIST_ERRCNT_EN
        chk("hold2_errcnt", 32'(ERR_CNT), 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
